mem_port_arbiter: RTL and testbench

Shares the single synchronous memory port between two requesters: the core's multicycle control path (port c) and the debug/program loader (port d). It arbitrates round-robin, with an optional debug burst lock. It latches the winning request, drives one memory access, waits the fixed read latency and returns read data to the owner. It sits between the core's memory interface and the unified instruction/data RAM.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between core (c) and debug (d) requesters.
// Round-robin arbitration with a bounded debug burst lock. Rev 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_W-1:0]     c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  input  logic [DATA_W/8-1:0]   c_wmask,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_W-1:0]     c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wmask,
  input  logic                  d_lock,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wmask,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic          owner;        // 0 = core, 1 = debug
  logic          last_winner;
  logic          lat_we;
  logic [1:0]    wait_cnt;
  logic [BW-1:0] burst_cnt;

  logic burst_sat;
  logic lock_win;
  logic win_d;

  assign burst_sat = (burst_cnt == BW'(MAX_BURST));
  assign lock_win  = d_req && d_lock && !burst_sat;

  // A saturated lock hands the next slot to a waiting core; otherwise plain round-robin.
  always_comb begin
    win_d = 1'b0;
    if (lock_win)
      win_d = 1'b1;
    else if (c_req && d_req)
      win_d = (burst_sat && d_lock) ? 1'b0 : !last_winner;
    else
      win_d = d_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_winner <= 1'b1;
      lat_we      <= 1'b0;
      wait_cnt    <= 2'd0;
      burst_cnt   <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_wmask     <= '0;
      c_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (c_req || d_req) begin
            owner       <= win_d;
            last_winner <= win_d;
            lat_we      <= win_d ? d_we    : c_we;
            m_addr      <= win_d ? d_addr  : c_addr;
            m_wdata     <= win_d ? d_wdata : c_wdata;
            m_wmask     <= win_d ? d_wmask : c_wmask;
            if (lock_win)
              burst_cnt <= burst_cnt + BW'(1);
            else if (!win_d || !d_lock)
              burst_cnt <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 2'(RD_LAT);
          state    <= lat_we ? IDLE : WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt == 2'd1) begin
            if (owner) d_rdata <= m_rdata;
            else       c_rdata <= m_rdata;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_en     = (state == ISSUE);
  assign m_we     = m_en && lat_we;
  assign c_gnt    = m_en && !owner;
  assign d_gnt    = m_en && owner;
  assign c_rvalid = (state == RESP) && !owner;
  assign d_rvalid = (state == RESP) && owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests of mem_port_arbiter at RD_LAT=1 and RD_LAT=3.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // RD_LAT = 1 instance
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_wmask, d_wmask;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;

  // RD_LAT = 3 instance
  logic        c3_req, c3_we, d3_req, d3_we, d3_lock;
  logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
  logic [3:0]  c3_wmask, d3_wmask;
  logic        c3_gnt, c3_rvalid, d3_gnt, d3_rvalid, m3_en, m3_we;
  logic [31:0] c3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic [3:0]  m3_wmask;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wmask(c_wmask),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_BURST(8)) dut3 (
    .clk(clk), .reset(reset),
    .c_req(c3_req), .c_we(c3_we), .c_addr(c3_addr), .c_wdata(c3_wdata), .c_wmask(c3_wmask),
    .c_gnt(c3_gnt), .c_rvalid(c3_rvalid), .c_rdata(c3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata), .d_wmask(d3_wmask),
    .d_lock(d3_lock), .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .m_en(m3_en), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_wmask(m3_wmask),
    .m_rdata(m3_rdata)
  );

  // Memory models: unwritten words read back a fixed pattern.
  function automatic logic [31:0] def_word(input logic [7:0] idx);
    return (idx == 8'd16) ? 32'hDEADBEEF : {24'hA00000, idx};
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [31:0] mem1 [256];
  logic [255:0] wr1 = '0;
  logic [31:0] rd1 = '0;
  logic [31:0] mem3 [256];
  logic [255:0] wr3 = '0;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0;

  function automatic logic [31:0] cur1(input logic [7:0] idx);
    return wr1[idx] ? mem1[idx] : def_word(idx);
  endfunction

  function automatic logic [31:0] cur3(input logic [7:0] idx);
    return wr3[idx] ? mem3[idx] : def_word(idx);
  endfunction

  always @(posedge clk) begin
    if (m_en && m_we) begin
      mem1[m_addr[9:2]] <= merge_word(cur1(m_addr[9:2]), m_wdata, m_wmask);
      wr1[m_addr[9:2]]  <= 1'b1;
    end
    if (m_en && !m_we) rd1 <= cur1(m_addr[9:2]);
  end
  assign m_rdata = rd1;

  always @(posedge clk) begin
    if (m3_en && m3_we) begin
      mem3[m3_addr[9:2]] <= merge_word(cur3(m3_addr[9:2]), m3_wdata, m3_wmask);
      wr3[m3_addr[9:2]]  <= 1'b1;
    end
    if (m3_en && !m3_we) p0 <= cur3(m3_addr[9:2]);
    p1 <= p0;
    p2 <= p1;
  end
  assign m3_rdata = p2;

  int rvc = 0;
  int rvd = 0;
  always @(posedge clk) begin
    if (c_rvalid) rvc <= rvc + 1;
    if (d_rvalid) rvd <= rvd + 1;
  end

  task automatic test_reset();
    checks++; if ({c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0", {c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we}); end
    checks++; if ({c_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", {c_rdata, d_rdata}); end
    checks++; if ({m_addr, m_wdata, m_wmask} !== 68'h0) begin
      errors++; $display("FAIL reset_mport got=%h exp=0", {m_addr, m_wdata, m_wmask}); end
    checks++; if ({c3_gnt, c3_rvalid, d3_gnt, d3_rvalid, m3_en, c3_rdata, d3_rdata, m3_addr} !== 101'h0) begin
      errors++; $display("FAIL reset_dut3 got=%h exp=0", {c3_gnt, c3_rvalid, d3_gnt, d3_rvalid, m3_en, c3_rdata, d3_rdata, m3_addr}); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    @(negedge clk);
    checks++; if ({c_gnt, m_en, m_we, d_gnt} !== 4'b1100) begin
      errors++; $display("FAIL single_issue got=%b exp=1100", {c_gnt, m_en, m_we, d_gnt}); end
    checks++; if (m_addr !== 32'h40) begin
      errors++; $display("FAIL single_addr got=%h exp=00000040", m_addr); end
    c_req = 1'b0;
    @(negedge clk);
    checks++; if ({c_rvalid, c_gnt} !== 2'b00) begin
      errors++; $display("FAIL single_wait got=%b exp=00", {c_rvalid, c_gnt}); end
    @(negedge clk);
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_resp got=%b/%h exp=1/deadbeef", c_rvalid, c_rdata); end
    checks++; if ({d_gnt, d_rvalid, d_rdata} !== 34'h0) begin
      errors++; $display("FAIL single_d_quiet got=%h exp=0", {d_gnt, d_rvalid, d_rdata}); end
    @(negedge clk);
    checks++; if (c_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_rvalid_pulse got=%b exp=0", c_rvalid); end
  endtask

  task automatic test_dual_write();
    int rv0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h11; c_wmask = 4'hF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h22; d_wmask = 4'hF;
    rv0 = rvc + rvd;
    @(negedge clk);
    checks++; if ({c_gnt, d_gnt, m_we} !== 3'b101 || m_addr !== 32'h10 || m_wdata !== 32'h11) begin
      errors++; $display("FAIL dual_first got=%b/%h/%h exp=101/10/11", {c_gnt, d_gnt, m_we}, m_addr, m_wdata); end
    c_req = 1'b0;
    @(negedge clk);
    checks++; if ({m_en, m_we} !== 2'b00 || m_addr !== 32'h10) begin
      errors++; $display("FAIL dual_idle got=%b/%h exp=00/10", {m_en, m_we}, m_addr); end
    @(negedge clk);
    checks++; if ({c_gnt, d_gnt, m_we} !== 3'b011 || m_addr !== 32'h20 || m_wdata !== 32'h22) begin
      errors++; $display("FAIL dual_second got=%b/%h/%h exp=011/20/22", {c_gnt, d_gnt, m_we}, m_addr, m_wdata); end
    d_req = 1'b0;
    @(negedge clk);
    checks++; if (mem1[4] !== 32'h11 || mem1[8] !== 32'h22) begin
      errors++; $display("FAIL dual_mem got=%h/%h exp=11/22", mem1[4], mem1[8]); end
    repeat (3) @(negedge clk);
    checks++; if (rvc + rvd !== rv0) begin
      errors++; $display("FAIL dual_no_rvalid got=%0d exp=%0d", rvc + rvd, rv0); end
  endtask

  task automatic test_alternate();
    int g, nrv;
    logic last;
    logic [31:0] ec, ed;
    g = 0; nrv = 0; last = 1'b0; ec = '0; ed = '0;
    c_we = 1'b0; d_we = 1'b0; d_lock = 1'b0;
    c_addr = 32'h80; d_addr = 32'h100;
    c_req = 1'b1; d_req = 1'b1;
    for (int cyc = 0; cyc < 80 && nrv < 6; cyc++) begin
      @(negedge clk);
      if (c_rvalid) begin
        nrv++;
        checks++; if (c_rdata !== ec || last !== 1'b0) begin
          errors++; $display("FAIL alt_c_resp got=%h/%b exp=%h/0", c_rdata, last, ec); end
      end
      if (d_rvalid) begin
        nrv++;
        checks++; if (d_rdata !== ed || last !== 1'b1) begin
          errors++; $display("FAIL alt_d_resp got=%h/%b exp=%h/1", d_rdata, last, ed); end
      end
      if (c_gnt || d_gnt) begin
        checks++; if (d_gnt !== g[0]) begin
          errors++; $display("FAIL alt_order grant=%0d got_d=%b exp_d=%b", g, d_gnt, g[0]); end
        last = d_gnt;
        if (c_gnt) begin ec = def_word(c_addr[9:2]); c_addr = c_addr + 32'd4; end
        else       begin ed = def_word(d_addr[9:2]); d_addr = d_addr + 32'd4; end
        g++;
        if (g == 6) begin c_req = 1'b0; d_req = 1'b0; end
      end
    end
    checks++; if (g !== 6 || nrv !== 6) begin
      errors++; $display("FAIL alt_counts got=%0d/%0d exp=6/6", g, nrv); end
  endtask

  task automatic test_lock_burst();
    int g;
    logic exp_d;
    g = 0;
    c_we = 1'b1; c_addr = 32'hC4; c_wdata = 32'h0000C0C0; c_wmask = 4'hF;
    d_we = 1'b1; d_addr = 32'hC8; d_wdata = 32'h0000D0D0; d_wmask = 4'hF;
    c_req = 1'b1; d_req = 1'b1; d_lock = 1'b1;
    for (int cyc = 0; cyc < 80 && g < 10; cyc++) begin
      @(negedge clk);
      if (c_gnt || d_gnt) begin
        exp_d = (g != 8);
        checks++; if ({d_gnt, c_gnt} !== {exp_d, !exp_d}) begin
          errors++; $display("FAIL lock_order grant=%0d got=%b exp=%b", g, {d_gnt, c_gnt}, {exp_d, !exp_d}); end
        g++;
        if (g == 10) begin c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0; end
      end
    end
    checks++; if (g !== 10) begin
      errors++; $display("FAIL lock_count got=%0d exp=10", g); end
    @(negedge clk);
    checks++; if (mem1[49] !== 32'h0000C0C0 || mem1[50] !== 32'h0000D0D0) begin
      errors++; $display("FAIL lock_mem got=%h/%h exp=c0c0/d0d0", mem1[49], mem1[50]); end
  endtask

  task automatic test_lat3();
    @(negedge clk);
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h40;
    @(negedge clk);
    checks++; if ({c3_gnt, m3_en, m3_we} !== 3'b110) begin
      errors++; $display("FAIL lat3_issue got=%b exp=110", {c3_gnt, m3_en, m3_we}); end
    c3_req = 1'b0;
    d3_req = 1'b1; d3_we = 1'b1; d3_addr = 32'h50; d3_wdata = 32'h55; d3_wmask = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if ({d3_gnt, c3_rvalid, m3_en} !== 3'b000) begin
        errors++; $display("FAIL lat3_wait%0d got=%b exp=000", k, {d3_gnt, c3_rvalid, m3_en}); end
    end
    @(negedge clk);
    checks++; if (c3_rvalid !== 1'b1 || c3_rdata !== 32'hDEADBEEF || d3_gnt !== 1'b0) begin
      errors++; $display("FAIL lat3_resp got=%b/%h/%b exp=1/deadbeef/0", c3_rvalid, c3_rdata, d3_gnt); end
    @(negedge clk);
    checks++; if ({d3_gnt, c3_rvalid} !== 2'b00) begin
      errors++; $display("FAIL lat3_idle got=%b exp=00", {d3_gnt, c3_rvalid}); end
    @(negedge clk);
    checks++; if ({d3_gnt, m3_we} !== 2'b11 || m3_addr !== 32'h50) begin
      errors++; $display("FAIL lat3_d_grant got=%b/%h exp=11/50", {d3_gnt, m3_we}, m3_addr); end
    d3_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem3[20] !== 32'h55 || d3_rvalid !== 1'b0) begin
      errors++; $display("FAIL lat3_d_write got=%h/%b exp=55/0", mem3[20], d3_rvalid); end
  endtask

  task automatic test_reset_mid();
    int rv0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_lock = 1'b0;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_issue got=%b exp=1", d_gnt); end
    d_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if ({c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we, c_rdata, d_rdata} !== 70'h0) begin
      errors++; $display("FAIL rmid_outputs got=%h exp=0", {c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we, c_rdata, d_rdata}); end
    checks++; if ({m_addr, m_wdata, m_wmask} !== 68'h0) begin
      errors++; $display("FAIL rmid_mport got=%h exp=0", {m_addr, m_wdata, m_wmask}); end
    rv0 = rvd;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rvd !== rv0) begin
      errors++; $display("FAIL rmid_no_rvalid got=%0d exp=%0d", rvd, rv0); end
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1 || m_addr !== 32'h40) begin
      errors++; $display("FAIL rmid_c_issue got=%b/%h exp=1/40", c_gnt, m_addr); end
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL rmid_c_resp got=%b/%h/%b exp=1/deadbeef/0", c_rvalid, c_rdata, d_rvalid); end
  endtask

  initial begin
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_wmask = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wmask = 0; d_lock = 0;
    c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0; c3_wmask = 0;
    d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0; d3_wmask = 0; d3_lock = 0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_single_read();
    test_dual_write();
    test_alternate();
    test_lock_burst();
    test_lat3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
